decode_queue: RTL and testbench

//  Fetch-to-decode pipeline stage that sequences the immediate generator.

---
 rtl/decode_queue.sv | 124 ++++++++++++
 tb/tb_decode_queue.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// Two-entry skid queue between fetch and decode. Each opcode is decoded when it is
// pushed into the queue, and the immediate-type select is stored with the entry.
//
//  state | meaning
//  EMPTY | no valid entry; head outputs hold stale data
//  ONE   | head valid, tail unused
//  TWO   | head and tail valid; fetch is stalled
module decode_queue #(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      out_immsel,
  output logic            out_illegal
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
    logic [4:0]      immsel;
    logic            illegal;
  } entry_t;

  state_t state_q, state_d;
  entry_t head_q, head_d;
  entry_t tail_q, tail_d;
  entry_t in_entry;
  logic   push, pop;

  // Returns {illegal, immsel}; every listed opcode ends in 2'b11, so a bad low pair is caught here too
  function automatic logic [5:0] decode_op(input logic [6:0] op);
    logic [5:0] r;
    case (op)
      7'b0000011, 7'b0010011, 7'b1100111,
      7'b0001111, 7'b1110011:              r = 6'b0_00001;
      7'b0100011:                          r = 6'b0_00010;
      7'b1100011:                          r = 6'b0_00100;
      7'b0110111, 7'b0010111:              r = 6'b0_01000;
      7'b1101111:                          r = 6'b0_10000;
      7'b0110011:                          r = 6'b0_00000;
      default:                             r = 6'b1_00000;
    endcase
    return r;
  endfunction

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    in_entry.instr                     = in_instr;
    in_entry.pc                        = in_pc;
    {in_entry.illegal, in_entry.immsel} = decode_op(in_instr[6:0]);
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = ONE;
            head_d  = in_entry;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_d = in_entry;
          end else if (push) begin
            state_d = TWO;
            tail_d  = in_entry;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            state_d = ONE;
            head_d  = tail_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign out_instr   = head_q.instr;
  assign out_pc      = head_q.pc;
  assign out_immsel  = head_q.immsel;
  assign out_illegal = head_q.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: hand sequences for reset, backpressure and flush,
// plus a table of opcode vectors streamed through with simultaneous push and pop.
module tb_decode_queue;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic        in_ready, out_valid, out_illegal;
  logic [31:0] in_instr, in_pc, out_instr, out_pc;
  logic [4:0]  out_immsel;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  immsel;
    logic        illegal;
  } vec_t;

  vec_t vecs[15];

  decode_queue #(.PC_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_immsel(out_immsel), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_instr  = instr;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic chk_head(input string name, input logic [31:0] instr, input logic [31:0] pc,
                          input logic [4:0] immsel, input logic illegal);
    chk({name, ".valid"},   {31'd0, out_valid},   32'd1);
    chk({name, ".instr"},   out_instr,            instr);
    chk({name, ".pc"},      out_pc,               pc);
    chk({name, ".immsel"},  {27'd0, out_immsel},  {27'd0, immsel});
    chk({name, ".illegal"}, {31'd0, out_illegal}, {31'd0, illegal});
  endtask

  initial begin
    vecs[0]  = '{32'h00000003, 32'h1000, 5'b00001, 1'b0};
    vecs[1]  = '{32'h00000013, 32'h1004, 5'b00001, 1'b0};
    vecs[2]  = '{32'h00000067, 32'h1008, 5'b00001, 1'b0};
    vecs[3]  = '{32'h0000000F, 32'h100C, 5'b00001, 1'b0};
    vecs[4]  = '{32'h00000073, 32'h1010, 5'b00001, 1'b0};
    vecs[5]  = '{32'h00000023, 32'h1014, 5'b00010, 1'b0};
    vecs[6]  = '{32'h00000063, 32'h1018, 5'b00100, 1'b0};
    vecs[7]  = '{32'h00000037, 32'h101C, 5'b01000, 1'b0};
    vecs[8]  = '{32'h00000017, 32'h1020, 5'b01000, 1'b0};
    vecs[9]  = '{32'h0000006F, 32'h1024, 5'b10000, 1'b0};
    vecs[10] = '{32'h00000033, 32'h1028, 5'b00000, 1'b0};
    vecs[11] = '{32'h0000007F, 32'h102C, 5'b00000, 1'b1};
    vecs[12] = '{32'h00000000, 32'h1030, 5'b00000, 1'b1};
    vecs[13] = '{32'hFFF00113, 32'h1034, 5'b00001, 1'b0};
    vecs[14] = '{32'h00000001, 32'h1038, 5'b00000, 1'b1};

    // reset with fetch presenting an instruction
    rst = 1'b1;
    drive(1'b1, 32'h00500093, 32'h40, 1'b0, 1'b0);
    step();
    step();
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst.instr",     out_instr,          32'd0);
    chk("rst.pc",        out_pc,             32'd0);
    chk("rst.immsel",    {27'd0, out_immsel}, 32'd0);
    chk("rst.illegal",   {31'd0, out_illegal}, 32'd0);
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    chk("rst.nocapture", {31'd0, out_valid}, 32'd0);

    // streaming
    drive(1'b1, 32'h00500093, 32'h100, 1'b1, 1'b0);
    step();
    chk_head("stream0", 32'h00500093, 32'h100, 5'b00001, 1'b0);
    chk("stream0.in_ready", {31'd0, in_ready}, 32'd1);
    drive(1'b1, 32'h00112023, 32'h104, 1'b1, 1'b0);
    step();
    chk_head("stream1", 32'h00112023, 32'h104, 5'b00010, 1'b0);
    chk("stream1.in_ready", {31'd0, in_ready}, 32'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    chk("stream.drained", {31'd0, out_valid}, 32'd0);

    // backpressure into TWO, then drain
    drive(1'b1, 32'h0000006F, 32'h200, 1'b0, 1'b0);
    step();
    chk_head("bp.jal", 32'h0000006F, 32'h200, 5'b10000, 1'b0);
    chk("bp.one.in_ready", {31'd0, in_ready}, 32'd1);
    drive(1'b1, 32'h000000B7, 32'h204, 1'b0, 1'b0);
    step();
    chk("bp.two.in_ready", {31'd0, in_ready}, 32'd0);
    chk_head("bp.hold0", 32'h0000006F, 32'h200, 5'b10000, 1'b0);
    drive(1'b1, 32'h00000063, 32'h208, 1'b0, 1'b0);
    step();
    chk("bp.stall.in_ready", {31'd0, in_ready}, 32'd0);
    chk_head("bp.hold1", 32'h0000006F, 32'h200, 5'b10000, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    chk_head("bp.lui", 32'h000000B7, 32'h204, 5'b01000, 1'b0);
    chk("bp.after.in_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("bp.drained", {31'd0, out_valid}, 32'd0);

    // flush from TWO with a same-cycle input
    drive(1'b1, 32'h00000013, 32'h300, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h00000023, 32'h304, 1'b0, 1'b0);
    step();
    chk("fl.two.in_ready", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 32'h00000037, 32'h308, 1'b0, 1'b1);
    step();
    chk("fl.out_valid", {31'd0, out_valid}, 32'd0);
    chk("fl.in_ready",  {31'd0, in_ready},  32'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    chk("fl.dropped", {31'd0, out_valid}, 32'd0);
    drive(1'b1, 32'h00000063, 32'h30C, 1'b1, 1'b0);
    step();
    chk_head("fl.next", 32'h00000063, 32'h30C, 5'b00100, 1'b0);

    // flush in ONE with a same-cycle pop
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    step();
    chk("fl1.out_valid", {31'd0, out_valid}, 32'd0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();

    // decode table streamed with push and pop every cycle; occupancy must stay at one
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, vecs[i].instr, vecs[i].pc, 1'b1, 1'b0);
      step();
      chk_head($sformatf("dec%0d", i), vecs[i].instr, vecs[i].pc, vecs[i].immsel, vecs[i].illegal);
      chk($sformatf("dec%0d.in_ready", i), {31'd0, in_ready}, 32'd1);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    chk("dec.drained", {31'd0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
